// File: rtl/spi_pkg.sv
// Shared definitions for the 16-bit SPI link: transmitter FSM states, word width
// and the receiver idle timeout that frames words on the clock/data-only link.
package spi_pkg;

   typedef enum logic [1:0] {
      SPI_IDLE  = 2'd0,
      SPI_SETUP = 2'd1,
      SPI_HIGH  = 2'd2,
      SPI_GAP   = 2'd3
   } spi_state_t;

   localparam int          SPI_WORD_WIDTH = 16;
   localparam logic [15:0] SPI_IDLE_TIME  = 16'h1FF;

endpackage

// File: rtl/spi_half_period_timer.sv
// Free-running divider: ticks on the cycle its count reaches the terminal value,
// restarts after each tick, and is forced back to zero by load.
module spi_half_period_timer #(
   parameter int WIDTH = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic             enable,
   input  logic [WIDTH-1:0] terminal,
   output logic             tick
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   assign tick = enable && (count_q == terminal);

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = '0;
      end else if (enable) begin
         count_d = tick ? '0 : count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/dac_spi_out.sv
// SPI master transmitter: MSB-first words, data launched on the falling SPI clock,
// clock parked low. Define DAC_SPI_OUT_CS_EN to add an active-low chip select.
module dac_spi_out
   import spi_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 8,
   parameter int DATA_WIDTH = SPI_WORD_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   output logic                  ready,
   output logic                  spi_clock_out,
   output logic                  spi_data_out,
`ifdef DAC_SPI_OUT_CS_EN
   output logic                  spi_cs_n,
`endif
   output logic                  data_sent
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(DATA_WIDTH);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_TERM = GAP_W'(GAP_CYCLES - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

   // A bit period must stay far inside the receiver's idle timeout or it would reframe mid-word.
   if (CLK_DIV < 2 || CLK_DIV > 255 || GAP_CYCLES < 2 ||
       2 * CLK_DIV >= int'(SPI_IDLE_TIME)) begin : g_bad_params
      $error("dac_spi_out: CLK_DIV must be 2..255 and GAP_CYCLES at least 2");
   end

   spi_state_t            state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic                  ready_q, spi_clock_q, spi_data_q, data_sent_q;
   logic                  accept, word_active;
   logic                  div_load, div_tick, gap_load, gap_tick;

   assign accept      = data_valid && ready_q;
   assign word_active = (state_q == SPI_SETUP) || (state_q == SPI_HIGH);

   spi_half_period_timer #(.WIDTH(DIV_W)) u_div_timer (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (div_load),
      .enable   (word_active),
      .terminal (DIV_TERM),
      .tick     (div_tick)
   );

   spi_half_period_timer #(.WIDTH(GAP_W)) u_gap_timer (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (gap_load),
      .enable   (state_q == SPI_GAP),
      .terminal (GAP_TERM),
      .tick     (gap_tick)
   );

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bit_d    = bit_q;
      div_load = 1'b0;
      gap_load = 1'b0;
      unique case (state_q)
         SPI_IDLE: begin
            if (accept) begin
               shift_d  = data_in;
               bit_d    = '0;
               div_load = 1'b1;
               state_d  = SPI_SETUP;
            end
         end
         SPI_SETUP: begin
            if (div_tick) state_d = SPI_HIGH;
         end
         SPI_HIGH: begin
            if (div_tick) begin
               if (bit_q == LAST_BIT) begin
                  gap_load = 1'b1;
                  state_d  = SPI_GAP;
               end else begin
                  shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                  bit_d   = bit_q + BIT_W'(1);
                  state_d = SPI_SETUP;
               end
            end
         end
         SPI_GAP: begin
            if (gap_tick) state_d = SPI_IDLE;
         end
         default: state_d = SPI_IDLE;
      endcase
   end

   // Pins are registered from the current state, so they trail the FSM by one cycle;
   // ready drops on the accepting edge itself so a held data_valid cannot double-load.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= SPI_IDLE;
         shift_q     <= '0;
         bit_q       <= '0;
         ready_q     <= 1'b1;
         spi_clock_q <= 1'b0;
         spi_data_q  <= 1'b0;
         data_sent_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_q       <= bit_d;
         ready_q     <= (state_q == SPI_IDLE) && !accept;
         spi_clock_q <= (state_q == SPI_HIGH);
         spi_data_q  <= word_active && shift_q[DATA_WIDTH-1];
         data_sent_q <= (state_q == SPI_IDLE) && !ready_q;
      end
   end

   assign ready         = ready_q;
   assign spi_clock_out = spi_clock_q;
   assign spi_data_out  = spi_data_q;
   assign data_sent     = data_sent_q;

`ifdef DAC_SPI_OUT_CS_EN
   logic spi_cs_n_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         spi_cs_n_q <= 1'b1;
      end else begin
         spi_cs_n_q <= !word_active;
      end
   end

   assign spi_cs_n = spi_cs_n_q;
`endif

endmodule

// File: doc/dac_spi_out.md
# dac_spi_out

SPI master transmitter that serialises 16-bit words onto a two-wire link (clock and data, no framing signal by default). It is the sending end of the link our 16-bit SPI slave receivers expect: MSB first, data stable while the clock is low, sampled by the receiver on the rising clock edge, clock parked low between words. It sits between internal sample producers and the external DAC/companion-FPGA pins, on the same system clock as the rest of the design.

## Interface
- CLK_DIV, 4: system clocks per SPI half-period; legal range 2..255. Must stay well below the receiver's idle timeout of 0x1FF.
- GAP_CYCLES, 8: system clocks the SPI clock is held low after the last bit, before the next word may start; minimum 2.
- DATA_WIDTH, 16: word length.
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- data_in  in  DATA_WIDTH  word to send; bit DATA_WIDTH-1 is transmitted first.
- data_valid  in  1  load request; a word is accepted on any edge where data_valid && ready.
- ready  out  1  high only in IDLE.
- spi_clock_out  out  1  SPI clock, idles low.
- spi_data_out  out  1  serial data.
- data_sent  out  1  one-cycle pulse when a word and its gap are complete.

## Operation
- Reset values: ready=1, spi_clock_out=0, spi_data_out=0, data_sent=0, state IDLE, all counters 0.
- States: IDLE, SETUP, HIGH, GAP.
- IDLE: on data_valid && ready, latch data_in into the shift register, clear the bit counter, and go to SETUP. data_valid is ignored in every other state. There is no queue.
- SETUP: spi_clock_out=0 and spi_data_out=current MSB of the shift register, for CLK_DIV cycles. Then go to HIGH.
- HIGH: spi_clock_out=1 for CLK_DIV cycles.
  - If the bit counter equals DATA_WIDTH-1, go to GAP.
  - Otherwise shift left by one, increment the bit counter, and go to SETUP.
- spi_data_out changes only on the SETUP entry edge, which coincides with the falling edge of spi_clock_out. It is never changed while the clock is high.
- GAP: spi_clock_out=0 and spi_data_out=0 for GAP_CYCLES. Then go to IDLE, with data_sent=1 for that single cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Counter widths:
  - Divider counter: $clog2(CLK_DIV) bits.
  - Bit counter: $clog2(DATA_WIDTH) bits; wraps only through reload.
  - Gap counter: $clog2(GAP_CYCLES+1) bits.
- Reset mid-word: outputs return to their reset values immediately (asynchronously) and the word is discarded. The partial word is recovered by the receiver's idle timeout.

## Timing
- Take the acceptance edge as edge 0.
  - SETUP for bit 15 is active after edge 1.
  - The first rising edge of spi_clock_out occurs at edge 1+CLK_DIV.
  - Each bit occupies 2*CLK_DIV cycles.
  - GAP begins at edge 1+2*CLK_DIV*DATA_WIDTH.
  - IDLE, ready=1 and data_sent=1 occur at edge 1+2*CLK_DIV*DATA_WIDTH+GAP_CYCLES (edge 137 with defaults).
- Maximum throughput is one word per 2*CLK_DIV*DATA_WIDTH+GAP_CYCLES+1 cycles: a back-to-back data_valid is accepted on the data_sent cycle.
- Data setup to the SPI rising edge is CLK_DIV cycles; hold after it is CLK_DIV cycles.

## Configuration
- DAC_SPI_OUT_CS_EN defined:
  - Adds output spi_cs_n (1 bit, reset value 1).
  - spi_cs_n is 0 throughout SETUP and HIGH for a word, and 1 in IDLE and GAP.
  - It falls on the same edge SETUP is entered for the first bit.
- Not defined: the port is absent and the link is clock/data only; the receiver frames words by bit count and timeout.

## Structure
- Shared package spi_pkg holds:
  - the spi_state_t enum (IDLE/SETUP/HIGH/GAP);
  - SPI_WORD_WIDTH=16;
  - SPI_IDLE_TIME=16'h1FF, used by the transmitter's parameter checks and by the receivers.
- One sub-module, spi_half_period_timer: a divider counter that emits a tick every CLK_DIV cycles when enabled and restarts on load. It is reused for the GAP count with a separate terminal value.

## Test plan
- Defaults, send 16'hA5C3:
  - exactly 16 rising edges on spi_clock_out;
  - bits sampled at the rising edges read 1010_0101_1100_0011;
  - data_sent is a single pulse at edge 137; ready is low for edges 1..136.
- Loopback into the 16-bit receiver, words 16'h0001 then 16'hFFFF back to back (second data_valid on the data_sent cycle) -> the receiver delivers 16'h0001 then 16'hFFFF with its received flag set for each.
- data_valid pulsed with 16'h1111 at edge 40 of a 16'h2222 transfer -> 16'h1111 ignored, only 16'h2222 on the wire, ready low throughout.
- reset_n low after the 5th SPI rising edge -> spi_clock_out and spi_data_out go 0 immediately, ready=1. After 0x200+ idle cycles, a 16'h1234 is received correctly by the receiver.
- CLK_DIV=2, GAP_CYCLES=2 -> each bit lasts 4 cycles, data_sent at edge 67, and the receiver still captures 16'h8001.
- With DAC_SPI_OUT_CS_EN -> spi_cs_n low from edge 1 through edge 128, high at edge 129, and 1 during reset.
